// File: rtl/cigar_pack_pkg.sv
// Shared types and constants for the CIGAR page arbiter.
package cigar_pack_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_XFER,
        ST_PAD
    } state_t;

    localparam logic [63:0] PAD_WORD       = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam int          HDR_LEN_LSB    = 0;
    localparam int          DEF_PAGE_WORDS = 512;
    localparam int          DEF_PAGE_W     = 10;

endpackage

// File: rtl/cigar_page_arbiter_rr_arbiter.sv
// Round-robin pick of the first requester after the stored pointer.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int REQ_W   = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_ptr_upd,
    input  logic [REQ_W-1:0]   i_ptr_val,
    output logic [REQ_W-1:0]   o_idx,
    output logic               o_valid
);
    import cigar_pack_pkg::*;

    logic [REQ_W-1:0] r_ptr;
    logic [REQ_W-1:0] w_cand;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= REQ_W'(NUM_REQ - 1);
        end else if (i_ptr_upd) begin
            r_ptr <= i_ptr_val;
        end
    end

    // Search starts one past the pointer; the pointer itself is checked last.
    always_comb begin
        o_idx   = r_ptr;
        o_valid = 1'b0;
        w_cand  = r_ptr;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = r_ptr + REQ_W'(k);
            if (!o_valid && i_req[w_cand]) begin
                o_valid = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/cigar_page_arbiter.sv
// Merges per-PU CIGAR record FIFOs into one page FIFO, padding so that
// no record straddles a page boundary.
//   state   | meaning
//   IDLE    | service pending flush or grant next requester
//   HDR     | inspect header of granted FIFO head
//   XFER    | forward record words
//   PAD     | write PAD_WORD up to the page boundary
module cigar_page_arbiter #(
    parameter int                NUM_REQ    = 4,
    parameter int                REQ_W      = 2,
    parameter int                DATA_W     = 64,
    parameter int                PAGE_WORDS = cigar_pack_pkg::DEF_PAGE_WORDS,
    parameter int                PAGE_W     = cigar_pack_pkg::DEF_PAGE_W,
    parameter logic [DATA_W-1:0] PAD_WORD   = DATA_W'(cigar_pack_pkg::PAD_WORD)
) (
    input  logic                      core_clk,
    input  logic                      core_rst,
    input  logic [NUM_REQ-1:0]        req_empty,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_rd_en,
    input  logic                      out_full,
    output logic                      out_wr_en,
    output logic [DATA_W-1:0]         out_data,
    input  logic                      flush_req,
    output logic                      page_done,
    output logic                      pad_active,
    output logic [REQ_W-1:0]          grant_idx,
    output logic                      record_err
);
    import cigar_pack_pkg::*;

    localparam logic [PAGE_W:0]   PAGE_WORDS_X = (PAGE_W + 1)'(PAGE_WORDS);
    localparam logic [PAGE_W-1:0] LAST_FILL    = PAGE_W'(PAGE_WORDS - 1);
    localparam logic [PAGE_W:0]   REM_ONE      = (PAGE_W + 1)'(1);

    state_t              r_state;
    logic [REQ_W-1:0]    r_grant;
    logic [PAGE_W-1:0]   r_fill;
    logic [PAGE_W:0]     r_rem;
    logic [PAGE_W:0]     r_len;
    logic                r_flush;
    logic                r_flush_pend;
    logic                r_err;
    logic                r_wr_en;
    logic [DATA_W-1:0]   r_data;
    logic                r_page_done;
    logic                r_pad_active;

    logic [DATA_W-1:0]   w_head;
    logic [PAGE_W:0]     w_len;
    logic [PAGE_W:0]     w_sum;
    logic                w_g_empty;
    logic                w_len_bad;
    logic                w_xfer;
    logic                w_drop;
    logic                w_pad_wr;
    logic                w_wrap;
    logic                w_ptr_upd;
    logic [REQ_W-1:0]    w_arb_idx;
    logic                w_arb_valid;

    assign w_head    = req_data[r_grant*DATA_W +: DATA_W];
    assign w_len     = {1'b0, w_head[HDR_LEN_LSB +: PAGE_W]};
    assign w_g_empty = req_empty[r_grant];
    assign w_len_bad = (w_len == '0) || (w_len > PAGE_WORDS_X);
    assign w_sum     = {1'b0, r_fill} + w_len;
    assign w_xfer    = (r_state == ST_XFER) && !w_g_empty && !out_full;
    assign w_drop    = (r_state == ST_HDR) && !w_g_empty && !out_full && w_len_bad;
    assign w_pad_wr  = (r_state == ST_PAD) && !out_full;
    assign w_wrap    = (r_fill == LAST_FILL);
    assign w_ptr_upd = w_xfer && (r_rem == REM_ONE);

    always_comb begin
        req_rd_en = '0;
        if (w_xfer || w_drop) begin
            req_rd_en[r_grant] = 1'b1;
        end
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .REQ_W   (REQ_W)
    ) u_rr_arbiter (
        .i_clk     (core_clk),
        .i_rst     (core_rst),
        .i_req     (~req_empty),
        .i_ptr_upd (w_ptr_upd),
        .i_ptr_val (r_grant),
        .o_idx     (w_arb_idx),
        .o_valid   (w_arb_valid)
    );

    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_fill       <= '0;
            r_rem        <= '0;
            r_len        <= '0;
            r_flush      <= 1'b0;
            r_flush_pend <= 1'b0;
            r_err        <= 1'b0;
            r_wr_en      <= 1'b0;
            r_data       <= PAD_WORD;
            r_page_done  <= 1'b0;
            r_pad_active <= 1'b0;
        end else begin
            r_wr_en      <= 1'b0;
            r_page_done  <= 1'b0;
            r_pad_active <= (r_state == ST_PAD);
            if (flush_req) begin
                r_flush_pend <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (r_flush_pend) begin
                        // A pulse landing on the clearing cycle stays pending.
                        if (r_fill == '0) begin
                            r_flush_pend <= flush_req;
                        end else begin
                            r_flush <= 1'b1;
                            r_state <= ST_PAD;
                        end
                    end else if (w_arb_valid) begin
                        r_grant <= w_arb_idx;
                        r_state <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (!w_g_empty) begin
                        if (w_len_bad) begin
                            if (!out_full) begin
                                r_err   <= 1'b1;
                                r_state <= ST_IDLE;
                            end
                        end else if (w_sum > PAGE_WORDS_X) begin
                            r_flush <= 1'b0;
                            r_len   <= w_len;
                            r_state <= ST_PAD;
                        end else begin
                            r_rem   <= w_len;
                            r_state <= ST_XFER;
                        end
                    end
                end
                ST_XFER: begin
                    if (w_xfer) begin
                        r_wr_en     <= 1'b1;
                        r_data      <= w_head;
                        r_rem       <= r_rem - 1'b1;
                        r_fill      <= w_wrap ? '0 : r_fill + 1'b1;
                        r_page_done <= w_wrap;
                        if (r_rem == REM_ONE) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_PAD: begin
                    if (w_pad_wr) begin
                        r_wr_en     <= 1'b1;
                        r_data      <= PAD_WORD;
                        r_fill      <= w_wrap ? '0 : r_fill + 1'b1;
                        r_page_done <= w_wrap;
                        if (w_wrap) begin
                            if (r_flush) begin
                                r_flush_pend <= flush_req;
                                r_state      <= ST_IDLE;
                            end else begin
                                r_rem   <= r_len;
                                r_state <= ST_XFER;
                            end
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign out_wr_en  = r_wr_en;
    assign out_data   = r_data;
    assign page_done  = r_page_done;
    assign pad_active = r_pad_active;
    assign grant_idx  = r_grant;
    assign record_err = r_err;

endmodule

// File: tb/tb_cigar_page_arbiter.sv
// Self-checking bench: directed record table, corner sequences, and a
// randomized run against a record-level reference model.
module tb_cigar_page_arbiter;
    localparam int NR = 4;
    localparam int DW = 64;
    localparam int PW = 512;
    localparam logic [63:0] PAD = 64'hFFFF_FFFF_FFFF_FFFF;

    logic             core_clk = 1'b0;
    logic             core_rst = 1'b1;
    logic [NR-1:0]    req_empty;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_rd_en;
    logic             out_full;
    logic             out_wr_en;
    logic [DW-1:0]    out_data;
    logic             flush_req;
    logic             page_done;
    logic             pad_active;
    logic [1:0]       grant_idx;
    logic             record_err;

    always #5 core_clk = ~core_clk;

    cigar_page_arbiter dut (
        .core_clk   (core_clk),
        .core_rst   (core_rst),
        .req_empty  (req_empty),
        .req_data   (req_data),
        .req_rd_en  (req_rd_en),
        .out_full   (out_full),
        .out_wr_en  (out_wr_en),
        .out_data   (out_data),
        .flush_req  (flush_req),
        .page_done  (page_done),
        .pad_active (pad_active),
        .grant_idx  (grant_idx),
        .record_err (record_err)
    );

    typedef struct {
        logic [63:0] data;
        bit          pd;
        bit          pad;
    } exp_t;

    typedef struct {
        int req;
        int len;
        int npads;
        bit pd_last;
        bit err;
        int grant;
    } vec_t;

    logic [63:0]   fq [NR][$];
    exp_t          exp_q[$];
    vec_t          tbl[9];
    int            n_tests = 0;
    int            n_fail = 0;
    int            full_mode = 0;
    logic [NR-1:0] rd_s;

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [63:0] hdr(int len);
        logic [63:0] w;
        w = {$urandom, $urandom};
        w[9:0] = len[9:0];
        return w;
    endfunction

    function automatic bit fq_busy();
        for (int i = 0; i < NR; i++) if (fq[i].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            req_empty[i] = (fq[i].size() == 0);
            req_data[i*DW +: DW] = (fq[i].size() != 0) ? fq[i][0] : '0;
        end
    endtask

    task automatic push_pads(int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.data = PAD; e.pd = (k == n - 1); e.pad = 1'b1;
            exp_q.push_back(e);
        end
    endtask

    task automatic push_rec(int r, int len, int nwords, bit add_exp, int npads, bit pd_last);
        logic [63:0] w;
        exp_t e;
        push_pads(npads);
        for (int k = 0; k < nwords; k++) begin
            w = (k == 0) ? hdr(len) : {$urandom, $urandom};
            fq[r].push_back(w);
            if (add_exp) begin
                e.data = w; e.pd = pd_last && (k == nwords - 1); e.pad = 1'b0;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic cycle();
        exp_t e;
        @(negedge core_clk);
        if (out_wr_en) begin
            if (exp_q.size() == 0) begin
                check("extra_write", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("out_data", out_data, e.data);
                check("page_done", page_done, e.pd);
                check("pad_active", pad_active, e.pad);
            end
        end else begin
            check("page_done_idle", page_done, 0);
        end
        check("rd_onehot", ($countones(req_rd_en) <= 1), 1);
        rd_s = req_rd_en;
        @(posedge core_clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (rd_s[i]) begin
                if (fq[i].size() == 0) check("pop_empty", 1, 0);
                else void'(fq[i].pop_front());
            end
        end
        flush_req = 1'b0;
        case (full_mode)
            0:       out_full = 1'b0;
            1:       out_full = ~out_full;
            default: out_full = ($urandom_range(0, 9) < 3);
        endcase
        drive();
    endtask

    task automatic drain(int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || fq_busy()) && n < budget) begin
            cycle();
            n++;
        end
        if (n >= budget) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: %0d words still expected after %0d cycles", exp_q.size(), n);
            exp_q.delete();
        end
        repeat (6) cycle();
    endtask

    task automatic do_reset();
        core_rst  = 1'b1;
        flush_req = 1'b0;
        out_full  = 1'b0;
        full_mode = 0;
        for (int i = 0; i < NR; i++) fq[i].delete();
        exp_q.delete();
        drive();
        @(posedge core_clk);
        #1;
        check("rst_wr_en", out_wr_en, 0);
        check("rst_data", out_data, PAD);
        check("rst_page_done", page_done, 0);
        check("rst_pad_active", pad_active, 0);
        check("rst_grant", grant_idx, 0);
        check("rst_err", record_err, 0);
        check("rst_rd_en", req_rd_en, 0);
        core_rst = 1'b0;
    endtask

    task automatic run_random();
        logic [63:0] mq [NR][$];
        logic [63:0] h;
        logic [63:0] w;
        exp_t e;
        int n, sel, len, p, g, fill, L;
        bit merr;
        do_reset();
        for (int r = 0; r < NR; r++) begin
            n = $urandom_range(1, 6);
            for (int j = 0; j < n; j++) begin
                sel = $urandom_range(0, 19);
                if (sel < 4)       len = $urandom_range(200, 512);
                else if (sel == 4) len = 0;
                else if (sel == 5) len = $urandom_range(513, 1023);
                else               len = $urandom_range(1, 16);
                push_rec(r, len, (len == 0 || len > PW) ? 1 : len, 1'b0, 0, 1'b0);
            end
        end
        // Record-level model: round robin over non-empty FIFOs, pad when a record would cross a page.
        for (int r = 0; r < NR; r++) mq[r] = fq[r];
        p = NR - 1; fill = 0; merr = 1'b0;
        while (1) begin
            g = -1;
            for (int k = 1; k <= NR; k++) begin
                if (g < 0 && mq[(p + k) % NR].size() != 0) g = (p + k) % NR;
            end
            if (g < 0) break;
            h = mq[g].pop_front();
            L = int'(h[9:0]);
            if (L == 0 || L > PW) begin
                merr = 1'b1;
                continue;
            end
            if (fill + L > PW) begin
                push_pads(PW - fill);
                fill = 0;
            end
            for (int k = 0; k < L; k++) begin
                w = (k == 0) ? h : mq[g].pop_front();
                fill++;
                e.data = w; e.pd = (fill == PW); e.pad = 1'b0;
                exp_q.push_back(e);
                if (fill == PW) fill = 0;
            end
            p = g;
        end
        full_mode = 2;
        drive();
        drain(40000);
        check("rand_record_err", record_err, merr);
        if (fill != 0) push_pads(PW - fill);
        flush_req = 1'b1;
        drain(3000);
        check("rand_pad_idle", pad_active, 0);
    endtask

    initial begin
        bit bad;
        req_empty = '1;
        req_data  = '0;
        out_full  = 1'b0;
        flush_req = 1'b0;
        tbl = '{
            '{0,   3, 0, 1'b0, 1'b0, 0},
            '{1,   2, 0, 1'b0, 1'b0, 1},
            '{0, 505, 0, 1'b0, 1'b0, 0},
            '{2,   4, 2, 1'b0, 1'b0, 2},
            '{3, 504, 0, 1'b0, 1'b0, 3},
            '{0,   4, 0, 1'b1, 1'b0, 0},
            '{1,   0, 0, 1'b0, 1'b1, 1},
            '{3, 600, 0, 1'b0, 1'b1, 3},
            '{2, 100, 0, 1'b0, 1'b1, 2}
        };
        do_reset();

        for (int i = 0; i < 9; i++) begin
            bad = (tbl[i].len == 0 || tbl[i].len > PW);
            push_rec(tbl[i].req, tbl[i].len, bad ? 1 : tbl[i].len, !bad, tbl[i].npads, tbl[i].pd_last);
            drive();
            drain(2000);
            check("tbl_grant", grant_idx, tbl[i].grant);
            check("tbl_err", record_err, tbl[i].err);
        end

        // Fill is 100 here: flush pads out the remaining 412 words.
        push_pads(PW - 100);
        flush_req = 1'b1;
        drain(3000);
        check("flush_pad_idle", pad_active, 0);
        flush_req = 1'b1;
        drain(50);

        do_reset();
        full_mode = 1;
        push_rec(0, 10, 10, 1'b1, 0, 1'b0);
        push_rec(1, 10, 10, 1'b1, 0, 1'b0);
        push_rec(2, 10, 10, 1'b1, 0, 1'b0);
        push_rec(3, 10, 10, 1'b1, 0, 1'b0);
        push_rec(0, 10, 10, 1'b1, 0, 1'b0);
        drive();
        drain(1000);
        check("rr_last_grant", grant_idx, 0);

        full_mode = 0;
        out_full  = 1'b0;
        push_rec(1, 10, 10, 1'b1, 0, 1'b0);
        drive();
        repeat (6) cycle();
        do_reset();
        // A full page right after reset must fit with no padding.
        push_rec(0, PW, PW, 1'b1, 0, 1'b1);
        drive();
        drain(2000);

        run_random();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
